// File: rtl/random_num.sv
// random_num: 4-bit pseudo-random index from a free-running 16-bit Galois LFSR.
// Define RANDOM_NUM_WHITEN_EN to XOR-fold all four LFSR nibbles into num.
module random_num #(
   parameter logic [15:0] SEED = 16'hACE1,
   parameter logic [15:0] POLY = 16'hB400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        seed_load,
   input  logic [15:0] seed_in,
   output logic [3:0]  num,
   output logic        valid
);
   logic [15:0] lfsr;
   logic [15:0] step;
   always_comb begin
      step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? POLY : 16'h0000);
`ifdef RANDOM_NUM_WHITEN_EN
      num = lfsr[15:12] ^ lfsr[11:8] ^ lfsr[7:4] ^ lfsr[3:0];
`else
      num = lfsr[3:0];
`endif
   end
   // A zero state would lock the LFSR forever, so it is replaced by SEED on any edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr  <= SEED;
         valid <= 1'b0;
      end else if (seed_load) begin
         lfsr  <= (seed_in != 16'h0000) ? seed_in : SEED;
         valid <= 1'b1;
      end else if (lfsr == 16'h0000) begin
         lfsr  <= SEED;
      end else if (en) begin
         lfsr  <= step;
         valid <= 1'b1;
      end
   end
endmodule

// File: tb/tb_random_num.sv
// tb_random_num: directed checks of reset, stepping, seed loads, hold, full period and mid-run reset.
module tb_random_num;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed_in = 16'h0000;
   logic [3:0]  num;
   logic        valid;
   int          n_cmp = 0;
   int          n_bad = 0;

   random_num dut (
      .clk(clk), .rst(rst), .en(en), .seed_load(seed_load),
      .seed_in(seed_in), .num(num), .valid(valid)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] exp_num(input logic [15:0] s);
`ifdef RANDOM_NUM_WHITEN_EN
      return s[15:12] ^ s[11:8] ^ s[7:4] ^ s[3:0];
`else
      return s[3:0];
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string name, input logic [15:0] e_lfsr, input logic e_valid);
      if (dut.lfsr !== e_lfsr) begin
         n_bad++;
         $display("FAIL %s lfsr: got %h expected %h", name, dut.lfsr, e_lfsr);
      end
      n_cmp++;
      if (num !== exp_num(e_lfsr)) begin
         n_bad++;
         $display("FAIL %s num: got %h expected %h", name, num, exp_num(e_lfsr));
      end
      n_cmp++;
      if (valid !== e_valid) begin
         n_bad++;
         $display("FAIL %s valid: got %b expected %b", name, valid, e_valid);
      end
      n_cmp++;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; seed_load = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check_state("reset", 16'hACE1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check_state("reset_hold", 16'hACE1, 1'b0);
      end
`ifdef RANDOM_NUM_WHITEN_EN
      if (num !== 4'h9) begin
         n_bad++;
         $display("FAIL reset_num_const: got %h expected 9", num);
      end
`else
      if (num !== 4'h1) begin
         n_bad++;
         $display("FAIL reset_num_const: got %h expected 1", num);
      end
`endif
      n_cmp++;
   endtask

   task automatic test_step();
      logic [15:0] seq [3] = '{16'hE270, 16'h7138, 16'h389C};
      rst = 1'b1; en = 1'b1;
      tick();
      check_state("step_rst", 16'hACE1, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_state("step", seq[i], 1'b1);
      end
   endtask

   task automatic test_seed_load();
      en = 1'b1; seed_load = 1'b1; seed_in = 16'h0000;
      tick();
      check_state("seed_zero", 16'hACE1, 1'b1);
      seed_in = 16'h1234;
      tick();
      check_state("seed_1234", 16'h1234, 1'b1);
      if (num !== 4'h4) begin
         n_bad++;
         $display("FAIL seed_num: got %h expected 4", num);
      end
      n_cmp++;
      seed_load = 1'b0;
      tick();
      check_state("seed_resume", 16'h091A, 1'b1);
   endtask

   task automatic test_seed_no_en();
      en = 1'b0; seed_load = 1'b1; seed_in = 16'h5A5A;
      tick();
      check_state("seed_no_en", 16'h5A5A, 1'b1);
      seed_load = 1'b0;
   endtask

   task automatic test_hold();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_state("hold", 16'h5A5A, 1'b1);
      end
   endtask

   task automatic test_period();
      int first = 0;
      int zeros = 0;
      int xs = 0;
      rst = 1'b1; en = 1'b0;
      tick();
      rst = 1'b0; en = 1'b1;
      for (int i = 1; i <= 65535; i++) begin
         tick();
         if (dut.lfsr == 16'h0000) zeros++;
         if ($isunknown(num)) xs++;
         if (dut.lfsr == 16'hACE1 && first == 0) first = i;
      end
      en = 1'b0;
      if (first !== 65535) begin
         n_bad++;
         $display("FAIL period: got %0d expected 65535", first);
      end
      n_cmp++;
      if (zeros !== 0) begin
         n_bad++;
         $display("FAIL zero_state: got %0d expected 0", zeros);
      end
      n_cmp++;
      if (xs !== 0) begin
         n_bad++;
         $display("FAIL num_unknown: got %0d expected 0", xs);
      end
      n_cmp++;
   endtask

   task automatic test_reset_mid();
      en = 1'b1;
      tick(); tick();
      check_state("mid_run", 16'h7138, 1'b1);
      rst = 1'b1; seed_load = 1'b1; seed_in = 16'h1234;
      tick();
      check_state("reset_mid", 16'hACE1, 1'b0);
      rst = 1'b0; seed_load = 1'b0; en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_step();
      test_seed_load();
      test_seed_no_en();
      test_hold();
      test_period();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
